// File: rtl/dma_pkg.sv
// dma_pkg: shared state enum, transfer-mode codes and mode-decode helper for the DMA controller
package dma_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, READ, WRITE, DONE} dma_state_t;
  localparam logic [1:0] MODE_IO_TO_MEM = 2'b00;
  localparam logic [1:0] MODE_MEM_TO_IO = 2'b01;
  localparam logic [1:0] MODE_MEM_TO_MEM = 2'b10;
  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    return {a, b, c} inside {3'b100, 3'b010, 3'b001};
  endfunction
endpackage

// File: rtl/dma_wait_ctr.sv
// dma_wait_ctr: saturating per-phase wait-cycle counter, sat flags MAX_WAIT reached
module dma_wait_ctr #(
  parameter int MAX_WAIT = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam int CW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_WAIT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst || clr ? '0 : inc && cnt != LIM ? cnt + 1'b1 : cnt;
  assign sat = cnt == LIM;
endmodule

// File: rtl/dma_transfer_control.sv
// dma_transfer_control: DMA bus-arbitration and READ/WRITE/DONE word-sequencing FSM (wait states when DMA_WAIT_STATE_EN is defined)
module dma_transfer_control #(
  parameter int MAX_WAIT = 7
) (
  input  logic CLK,
  input  logic RESET,
  input  logic DREQ,
  input  logic HLDA,
  input  logic CS,
  input  logic cpu_ior,
  input  logic cpu_iow,
  input  logic READY,
  input  logic io_to_mem,
  input  logic mem_to_io,
  input  logic mem_to_mem,
  input  logic terminal_count,
  output logic HRQ,
  output logic DACK,
  output logic MEMR,
  output logic MEMW,
  output logic IOR,
  output logic IOW,
  output logic EOP,
  output logic ProgramMode,
  output logic StateRead,
  output logic StateWrite,
  output logic StateDone,
  output logic ior,
  output logic iow
);
  import dma_pkg::*;
  dma_state_t state;
  logic [1:0] mode;
  logic go, adv;
  assign mode = mem_to_mem ? MODE_MEM_TO_MEM : mem_to_io ? MODE_MEM_TO_IO : MODE_IO_TO_MEM;
  assign go = DREQ && !CS && one_hot3(io_to_mem, mem_to_io, mem_to_mem);
`ifdef DMA_WAIT_STATE_EN
  logic busy, sat;
  assign busy = state == READ || state == WRITE;
  assign adv = READY || sat;
  dma_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk(CLK),
    .rst(RESET),
    .clr(!busy || adv),
    .inc(busy && !adv),
    .sat(sat)
  );
`else
  logic unused_ready;
  assign unused_ready = READY ^ (MAX_WAIT == 0);
  assign adv = 1'b1;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else
      case (state)
        IDLE:    state <= go ? HOLD : IDLE;
        HOLD:    state <= HLDA ? READ : HOLD;
        READ:    state <= adv ? WRITE : READ;
        WRITE:   state <= adv ? DONE : WRITE;
        DONE:    state <= terminal_count || !HLDA ? IDLE : READ;
        default: state <= IDLE;
      endcase
  end
  assign HRQ = state != IDLE;
  assign StateRead = state == READ;
  assign StateWrite = state == WRITE;
  assign StateDone = state == DONE;
  assign ProgramMode = state == IDLE && CS && !HLDA;
  assign ior = ProgramMode && cpu_ior;
  assign iow = ProgramMode && cpu_iow;
  assign IOR = StateRead && mode == MODE_IO_TO_MEM;
  assign MEMR = StateRead && mode != MODE_IO_TO_MEM;
  assign MEMW = StateWrite && mode != MODE_MEM_TO_IO;
  assign IOW = StateWrite && mode == MODE_MEM_TO_IO;
  assign DACK = IOR || IOW;
  assign EOP = StateDone && terminal_count;
endmodule

// File: tb/tb_dma_transfer_control.sv
// tb_dma_transfer_control: scoreboard bench for dma_transfer_control using directed per-cycle vectors
module tb_dma_transfer_control;
  logic CLK = 0, RESET = 1, DREQ = 0, HLDA = 0, CS = 0, cpu_ior = 0, cpu_iow = 0, READY = 1;
  logic io_to_mem = 0, mem_to_io = 0, mem_to_mem = 0, terminal_count = 0;
  logic HRQ, DACK, MEMR, MEMW, IOR, IOW, EOP, ProgramMode, StateRead, StateWrite, StateDone, ior, iow;
  logic [12:0] outs;
  typedef struct {
    string nm;
    logic [12:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0, passes = 0;
  localparam logic [12:0] B_HRQ = 13'h1000, B_DACK = 13'h0800, B_MEMR = 13'h0400, B_MEMW = 13'h0200;
  localparam logic [12:0] B_IOR = 13'h0100, B_IOW = 13'h0080, B_EOP = 13'h0040, B_PM = 13'h0020;
  localparam logic [12:0] B_SR = 13'h0010, B_SW = 13'h0008, B_SD = 13'h0004, B_CIOR = 13'h0002, B_CIOW = 13'h0001;
  localparam logic [12:0] IO_R = B_HRQ | B_DACK | B_IOR | B_SR;
  localparam logic [12:0] MEM_W = B_HRQ | B_MEMW | B_SW;
  localparam logic [12:0] MEM_R = B_HRQ | B_MEMR | B_SR;
  localparam logic [12:0] IO_W = B_HRQ | B_DACK | B_IOW | B_SW;
  localparam logic [12:0] DN = B_HRQ | B_SD;
  dma_transfer_control #(.MAX_WAIT(3)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .CS(CS),
    .cpu_ior(cpu_ior), .cpu_iow(cpu_iow), .READY(READY),
    .io_to_mem(io_to_mem), .mem_to_io(mem_to_io), .mem_to_mem(mem_to_mem),
    .terminal_count(terminal_count),
    .HRQ(HRQ), .DACK(DACK), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW), .EOP(EOP),
    .ProgramMode(ProgramMode), .StateRead(StateRead), .StateWrite(StateWrite), .StateDone(StateDone),
    .ior(ior), .iow(iow)
  );
  assign outs = {HRQ, DACK, MEMR, MEMW, IOR, IOW, EOP, ProgramMode, StateRead, StateWrite, StateDone, ior, iow};
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checks++;
      if (outs === cur.exp) passes++;
      else $display("FAIL %s: got %b want %b", cur.nm, outs, cur.exp);
    end
  end
  task automatic cyc(input string nm, input logic d, input logic h, input logic t, input logic [12:0] e);
    exp_t x;
    DREQ = d;
    HLDA = h;
    terminal_count = t;
    x.nm = nm;
    x.exp = e;
    sb.push_back(x);
    @(posedge CLK);
    #1;
  endtask
  task automatic word(input string p, input logic [12:0] r, input logic [12:0] w, input logic last);
    cyc({p, "_read"}, 0, 1, 0, r);
    cyc({p, "_write"}, 0, 1, 0, w);
    cyc({p, "_done"}, 0, 1, last, last ? DN | B_EOP : DN);
  endtask
  initial begin
    @(posedge CLK);
    #1;
    cyc("reset", 0, 0, 0, 13'h0);
    RESET = 0;
    io_to_mem = 1;
    CS = 1;
    cpu_iow = 1;
    cyc("prog", 0, 0, 0, B_PM | B_CIOW);
    cyc("prog_dreq", 1, 0, 0, B_PM | B_CIOW);
    CS = 0;
    cpu_iow = 0;
    cyc("cs_blocks_hrq", 0, 0, 0, 13'h0);
    cyc("io_dreq", 1, 0, 0, 13'h0);
    cyc("io_hold_wait", 0, 0, 0, B_HRQ);
    cyc("io_hold_hlda", 0, 1, 0, B_HRQ);
    word("io_w1", IO_R, MEM_W, 0);
    CS = 1;
    cpu_ior = 1;
    word("io_w2_cs", IO_R, MEM_W, 0);
    CS = 0;
    cpu_ior = 0;
    word("io_w3", IO_R, MEM_W, 1);
    cyc("io_end", 0, 0, 0, 13'h0);
    io_to_mem = 0;
    cyc("mode11_dreq", 1, 0, 0, 13'h0);
    cyc("mode11_stay", 0, 0, 0, 13'h0);
    mem_to_mem = 1;
    cyc("mm_dreq", 1, 0, 0, 13'h0);
    cyc("mm_hold", 0, 1, 0, B_HRQ);
    word("mm", MEM_R, MEM_W, 1);
    cyc("mm_end", 0, 0, 0, 13'h0);
    mem_to_mem = 0;
    mem_to_io = 1;
    cyc("mi_dreq", 1, 0, 0, 13'h0);
    cyc("mi_hold", 0, 1, 0, B_HRQ);
    cyc("mi_w1_read", 0, 1, 0, MEM_R);
    cyc("mi_w1_write_drop", 0, 0, 0, IO_W);
    cyc("mi_w1_done", 0, 0, 0, DN);
    cyc("mi_resume", 1, 0, 0, 13'h0);
    cyc("mi_hold2", 0, 1, 0, B_HRQ);
    word("mi_w2", MEM_R, IO_W, 0);
    word("mi_w3", MEM_R, IO_W, 0);
    word("mi_w4", MEM_R, IO_W, 1);
    cyc("mi_end", 0, 0, 0, 13'h0);
    mem_to_io = 0;
    io_to_mem = 1;
    cyc("rs_dreq", 1, 0, 0, 13'h0);
    cyc("rs_hold", 0, 1, 0, B_HRQ);
    RESET = 1;
    cyc("rs_read", 0, 1, 0, IO_R);
    RESET = 0;
    cyc("rs_after", 0, 1, 0, 13'h0);
    cyc("rs_idle", 0, 0, 0, 13'h0);
`ifdef DMA_WAIT_STATE_EN
    cyc("ws_dreq", 1, 0, 0, 13'h0);
    cyc("ws_hold", 0, 1, 0, B_HRQ);
    READY = 0;
    cyc("ws_r1", 0, 1, 0, IO_R);
    cyc("ws_r2", 0, 1, 0, IO_R);
    READY = 1;
    cyc("ws_r3", 0, 1, 0, IO_R);
    cyc("ws_write", 0, 1, 0, MEM_W);
    cyc("ws_done", 0, 1, 1, DN | B_EOP);
    cyc("ws_end", 0, 0, 0, 13'h0);
    cyc("st_dreq", 1, 0, 0, 13'h0);
    cyc("st_hold", 0, 1, 0, B_HRQ);
    READY = 0;
    cyc("st_r1", 0, 1, 0, IO_R);
    cyc("st_r2", 0, 1, 0, IO_R);
    cyc("st_r3", 0, 1, 0, IO_R);
    cyc("st_r4", 0, 1, 0, IO_R);
    READY = 1;
    cyc("st_write", 0, 1, 0, MEM_W);
    cyc("st_done", 0, 1, 1, DN | B_EOP);
    cyc("st_end", 0, 0, 0, 13'h0);
`else
    READY = 0;
    cyc("nr_dreq", 1, 0, 0, 13'h0);
    cyc("nr_hold", 0, 1, 0, B_HRQ);
    word("nr", IO_R, MEM_W, 1);
    READY = 1;
    cyc("nr_end", 0, 0, 0, 13'h0);
`endif
    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dma_transfer_control.md
# dma_transfer_control

Control FSM for the single-channel DMA, sitting directly beside the DMA datapath and driving its control inputs. It does four jobs:
- arbitrates for the bus with the CPU through HRQ/HLDA;
- tells the datapath when it is being programmed;
- sequences each word as READ → WRITE → DONE and drives the matching memory/IO strobes and DACK;
- repeats words until the datapath reports terminal count, then releases the bus.

## Interface
Parameters:
- MAX_WAIT, default 7: wait-cycle limit per READ/WRITE phase. Used only when DMA_WAIT_STATE_EN is defined.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock; all flops on posedge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  1  IO device request.
- HLDA  in  1  CPU hold acknowledge.
- CS  in  1  CPU chip select for register programming.
- cpu_ior, cpu_iow  in  1 each  CPU read/write strobes.
- READY  in  1  slave ready. Ignored unless DMA_WAIT_STATE_EN is defined.
- io_to_mem, mem_to_io, mem_to_mem  in  1 each  mode decodes from the datapath.
- terminal_count  in  1  from the datapath; valid only in DONE.
- HRQ  out  1  hold request to the CPU.
- DACK  out  1  acknowledge to the IO device.
- MEMR, MEMW, IOR, IOW  out  1 each  active-high bus strobes.
- EOP  out  1  end-of-block pulse.
- ProgramMode, StateRead, StateWrite, StateDone  out  1 each  datapath controls.
- ior, iow  out  1 each  strobes to the datapath.

## Operation
States: IDLE, HOLD, READ, WRITE, DONE.

Transitions:
- IDLE → HOLD when DREQ && !CS && exactly one mode decode is high. Mode 11 (no decode high) ignores DREQ.
- HOLD → READ when HLDA. Otherwise stay in HOLD.
- READ → WRITE after one cycle.
- WRITE → DONE after one cycle.
- DONE → IDLE when terminal_count. Otherwise DONE → READ while HLDA stays high.

Outputs, decoded from state (Moore):
- HRQ = 1 in HOLD, READ, WRITE, DONE.
- ProgramMode = (state == IDLE) && CS && !HLDA. While it is high, ior = cpu_ior and iow = cpu_iow; otherwise both are 0.
- StateRead, StateWrite and StateDone are each 1 only in the matching state.
- READ strobes: io_to_mem → IOR + DACK; mem_to_io and mem_to_mem → MEMR.
- WRITE strobes: io_to_mem → MEMW; mem_to_io → IOW + DACK; mem_to_mem → MEMW.
- EOP = 1 in DONE when terminal_count is high.

Block semantics:
- DREQ is sampled only in IDLE. Once started, the block runs until terminal count.
- A programmed word count of N transfers N+1 words. This matches the datapath's decrement-at-DONE, reload-at-zero behaviour.

Boundary conditions:
- HLDA falls during READ or WRITE: finish the current word through DONE, then go to IDLE without EOP. Current registers keep their values. The next DREQ resumes the block.
- CS during a transfer is ignored; ProgramMode stays 0.
- DREQ and CS high together in IDLE: CS wins, no HRQ.
- RESET at any point: next state IDLE. All outputs are 0 in the following cycle.

## Timing
- Reset value of every output is 0.
- DREQ sampled high in IDLE at edge k → HRQ high in cycle k+1.
- HLDA sampled high in HOLD at edge j → READ in cycle j+1, WRITE in j+2, DONE in j+3.
- Without wait states, each word takes exactly 3 cycles. Back-to-back words show no idle cycle between them.
- The datapath latches DB at the posedge that ends READ.
- HRQ falls in the cycle after the final DONE.

## Configuration
- DMA_WAIT_STATE_EN defined:
  - READ and WRITE hold while READY == 0.
  - A wait counter is cleared on phase entry and incremented each waiting cycle.
  - When the counter reaches MAX_WAIT, the phase is forced onward even if READY is still 0.
  - Strobes stay asserted for the whole extended phase.
- DMA_WAIT_STATE_EN undefined: READY is ignored and every phase is exactly 1 cycle.

## Structure
- Shared package dma_pkg holds:
  - the state enum (dma_state_t: IDLE, HOLD, READ, WRITE, DONE);
  - the mode constants MODE_IO_TO_MEM = 2'b00, MODE_MEM_TO_IO = 2'b01, MODE_MEM_TO_MEM = 2'b10.
- One sub-module, dma_wait_ctr: the saturating wait counter. Instantiated only under DMA_WAIT_STATE_EN.

## Test plan
- **Programming:** RESET, then CS=1 with cpu_iow=1, HLDA=0 → ProgramMode=1, iow=1, HRQ=0. Raising DREQ during this → still no HRQ.
- **io_to_mem block:** word count 2, DREQ pulse → HRQ next cycle. After HLDA, 3 words with per-phase strobes IOR+DACK / MEMW / none. EOP only on the third DONE; HRQ=0 the cycle after.
- **mem_to_mem:** word count 0 → single word, MEMR then MEMW, DACK never asserted, EOP=1 in the only DONE.
- **HLDA drop:** HLDA falls during the WRITE of word 1 of 4 → that word completes DONE, then IDLE with EOP=0. The next DREQ resumes and EOP appears after the remaining words.
- **Reset mid-block:** RESET asserted in READ → next cycle IDLE and all outputs 0.
- **Wait states (macro on, MAX_WAIT=3):**
  - READY=0 for 2 cycles in READ → READ lasts 3 cycles.
  - READY stuck at 0 → READ lasts 4 cycles, then WRITE.
